// File: rtl/cache_pkg.sv
// cache_pkg: FSM state encoding and geometry helper shared by the dcache_wt slice
package cache_pkg;
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RD_MISS = 2'd1,
        ST_WR_THRU = 2'd2
    } state_t;

    function automatic int tag_width(input int nlines);
        return 30 - $clog2(nlines);
    endfunction
endpackage

// File: rtl/sat_counter.sv
// sat_counter: up-counter that sticks at all-ones, async active-low clear
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] count
);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            count <= '0;
        else if (inc && count != '1)
            count <= count + 1'b1;
endmodule

// File: rtl/dcache_wt.sv
// dcache_wt: direct-mapped write-through no-write-allocate data cache with one-word lines
module dcache_wt
    import cache_pkg::*;
#(
    parameter int NLINES = 64,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      cpu_addr,
    input  logic             cpu_rd,
    input  logic             cpu_wr,
    input  logic [31:0]      cpu_wdata,
    output logic [31:0]      cpu_rdata,
    output logic             cpu_stall,
    output logic             mem_req,
    output logic             mem_we,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    input  logic             mem_ack,
    input  logic [31:0]      mem_rdata,
    output logic [CNT_W-1:0] hit_cnt,
    output logic [CNT_W-1:0] miss_cnt
);
    localparam int IB = $clog2(NLINES);
    localparam int TW = tag_width(NLINES);

    logic [NLINES-1:0] valid;
    logic [TW-1:0]     tags [NLINES];
    logic [31:0]       data [NLINES];
    state_t            state;
    logic [31:0]       rdata_q;
    logic [IB-1:0]     index;
    logic [TW-1:0]     tag;
    logic              hit, rd, wr, idle, fill, wr_upd;

    assign index  = cpu_addr[IB+1:2];
    assign tag    = cpu_addr[31:IB+2];
    assign hit    = valid[index] && tags[index] == tag;
    assign wr     = cpu_wr;
    assign rd     = cpu_rd && !cpu_wr;
    assign idle   = state == ST_IDLE;
    assign fill   = state == ST_RD_MISS && mem_ack;
    assign wr_upd = state == ST_WR_THRU && mem_ack && hit;

    // Hit data and the miss bypass are combinational; otherwise hold the last load value
    assign cpu_rdata = (idle && rd && hit) ? data[index] : fill ? mem_rdata : rdata_q;
    assign cpu_stall = rst_n && (idle ? (wr || (rd && !hit)) : !mem_ack);

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state     <= ST_IDLE;
            valid     <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rdata_q   <= '0;
        end else begin
            rdata_q <= cpu_rdata;
            case (state)
                ST_IDLE:
                    if (wr || (rd && !hit)) begin
                        mem_req  <= 1'b1;
                        mem_we   <= wr;
                        mem_addr <= cpu_addr & ~32'd3;
                        if (wr) mem_wdata <= cpu_wdata;
                        state    <= wr ? ST_WR_THRU : ST_RD_MISS;
                    end
                ST_RD_MISS:
                    if (mem_ack) begin
                        valid[index] <= 1'b1;
                        mem_req      <= 1'b0;
                        state        <= ST_IDLE;
                    end
                ST_WR_THRU:
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        state   <= ST_IDLE;
                    end
                default: state <= ST_IDLE;
            endcase
        end

    // Storage carries no reset; the valid bits gate every use of it
    always_ff @(posedge clk)
        if (fill || wr_upd) begin
            tags[index] <= tag;
            data[index] <= fill ? mem_rdata : cpu_wdata;
        end

    sat_counter #(.W(CNT_W)) u_hit (
        .clk(clk), .rst_n(rst_n), .inc(idle && rd && hit), .count(hit_cnt)
    );
    sat_counter #(.W(CNT_W)) u_miss (
        .clk(clk), .rst_n(rst_n), .inc(idle && rd && !hit), .count(miss_cnt)
    );
endmodule
